// File: rtl/disp_ram_write_ctrl_if.sv
// Display RAM port-A bundle: MicroBlaze GPO write request in, registered RAM write port out.
// master = write controller, slave = GPO/RAM side.
interface disp_ram_write_ctrl_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 24
);
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_din;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;

  modport master (
    input  cpu_we, cpu_addr, cpu_din,
    output ram_we, ram_addr, ram_din
  );

  modport slave (
    output cpu_we, cpu_addr, cpu_din,
    input  ram_we, ram_addr, ram_din
  );
endinterface

// File: rtl/disp_ram_write_ctrl.sv
// Display RAM port-A arbiter: queued GPO writes plus a full-frame clear engine; CPU write lands 3 cycles after strobe sample.
// Clear owns the port for NUM_WORDS cycles; CPU pushes queue meanwhile and are dropped (sticky ovf) once the FIFO is full.
module disp_ram_write_ctrl #(
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 24,
  parameter int NUM_WORDS  = 128,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  disp_ram_write_ctrl_if.master bus,
  input  logic                  clr_start,
  input  logic [DATA_W-1:0]     clr_color,
  input  logic                  ovf_clr,
  output logic                  busy,
  output logic                  ovf
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(NUM_WORDS - 1);
  localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_ent_t;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic              pop, clr_load, clr_wr;

  logic              we_q1, we_q2;
  logic              strobe_edge;

  wr_ent_t           fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    fifo_cnt;
  logic              fifo_empty, fifo_full;
  logic              push, drop;
  wr_ent_t           head;

  logic [CNT_W-1:0]  clr_cnt;
  logic [DATA_W-1:0] clr_col;

  logic              ram_we_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_din_q;

  // The GPO strobe is a level; only its rising edge (seen through two flops) requests a write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q1 <= 1'b0;
      we_q2 <= 1'b0;
    end else begin
      we_q1 <= bus.cpu_we;
      we_q2 <= we_q1;
    end
  end

  assign strobe_edge = we_q1 & ~we_q2;

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == FIFO_FULL);
  assign push       = strobe_edge & (~fifo_full | pop);
  assign drop       = strobe_edge & fifo_full & ~pop;
  assign head       = fifo_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= '{addr: bus.cpu_addr, data: bus.cpu_din};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (PTR_W + 1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (PTR_W + 1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // A drop in the same cycle as ovf_clr keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // clr_start outranks a pending CPU entry, so writes queued alongside it land after the frame fill.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    clr_load  = 1'b0;
    clr_wr    = 1'b0;
    case (state)
      IDLE: begin
        if (clr_start) begin
          clr_load  = 1'b1;
          state_nxt = CLEAR;
        end else if (!fifo_empty) begin
          pop = 1'b1;
        end
      end
      CLEAR: begin
        clr_wr = 1'b1;
        if (clr_cnt == CNT_LAST) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_cnt <= '0;
      clr_col <= '0;
    end else if (clr_load) begin
      clr_cnt <= '0;
      clr_col <= clr_color;
    end else if (clr_wr) begin
      clr_cnt <= clr_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
    end else if (clr_wr) begin
      ram_we_q   <= 1'b1;
      ram_addr_q <= clr_cnt[ADDR_W-1:0];
      ram_din_q  <= clr_col;
    end else if (pop) begin
      ram_we_q   <= 1'b1;
      ram_addr_q <= head.addr;
      ram_din_q  <= head.data;
    end else begin
      ram_we_q   <= 1'b0;
    end
  end

  assign bus.ram_we   = ram_we_q;
  assign bus.ram_addr = ram_addr_q;
  assign bus.ram_din  = ram_din_q;

  assign busy = (state == CLEAR) | ~fifo_empty | ram_we_q;

endmodule

// File: doc/disp_ram_write_ctrl.md
Name: disp_ram_write_ctrl

Overview:
- Owns the write port (port A) of the 128x24 display RAM and shares it between two requesters.
- Requester 1: the MicroBlaze GPO write path (address, data and write-strobe GPOs). Its writes are queued in a small FIFO.
- Requester 2: an internal hardware clear engine. It fills the whole frame with one colour at one word per cycle.
- Sits between the MicroBlaze GPO outputs and the display RAM, on the 100 MHz clock domain.

Parameters:
- ADDR_W, 7, RAM address width.
- DATA_W, 24, RGB word width (8 bits per colour).
- NUM_WORDS, 128, number of words the clear engine writes (addresses 0..NUM_WORDS-1).
- FIFO_DEPTH, 4, CPU write queue depth (power of 2).

Ports:
- clk  in  1  write-domain clock (100 MHz).
- rst_n  in  1  asynchronous, active-low reset.
- cpu_we  in  1  GPO write strobe, level signal; each rising edge requests one write.
- cpu_addr  in  ADDR_W  GPO write address; sampled with the strobe edge.
- cpu_din  in  DATA_W  GPO write data; sampled with the strobe edge.
- clr_start  in  1  single-cycle pulse that starts a full-frame clear.
- clr_color  in  DATA_W  fill colour; latched on an accepted clr_start.
- ovf_clr  in  1  clears the sticky overflow flag.
- ram_we  out  1  RAM port A write enable.
- ram_addr  out  ADDR_W  RAM port A address.
- ram_din  out  DATA_W  RAM port A data.
- busy  out  1  high while clearing or while the FIFO is non-empty.
- ovf  out  1  sticky flag: a CPU write was dropped.

Behaviour:
- Reset (async, rst_n=0):
  - ram_we=0, ram_addr=0, ram_din=0, busy=0, ovf=0.
  - FIFO emptied, state=IDLE, clear counter=0, cpu_we history registers=0.
  - Reset asserted mid-clear aborts the clear; no write is issued after release until a new request arrives.
- RAM outputs are registered. ram_we is high for exactly one cycle per write; ram_addr/ram_din are valid in that cycle and hold their last value otherwise.
- CPU strobe capture:
  - cpu_we passes through two flops (q1, q2). edge = q1 & ~q2.
  - On edge, {cpu_addr, cpu_din} sampled at that clock is pushed into the FIFO. The GPO values are stable by then.
  - Holding cpu_we high produces one push only.
- FIFO rules:
  - Push while full with no simultaneous pop: entry dropped, ovf set to 1.
  - Push while full with a simultaneous pop: push accepted.
  - ovf stays 1 until ovf_clr=1. If ovf_clr and a new drop occur in the same cycle, ovf ends at 1 (set wins).
- State machine, two states:
  - IDLE:
    - If clr_start=1: latch clr_color, counter<=0, go to CLEAR. No pop in this cycle.
    - Otherwise, if FIFO non-empty: pop one entry; the next cycle drives ram_we=1 with that address/data.
  - CLEAR:
    - Each cycle drives ram_we=1, ram_addr=counter, ram_din=latched colour, counter++.
    - After address NUM_WORDS-1: go to IDLE.
    - No FIFO pops during CLEAR; CPU pushes still accepted.
    - clr_start during CLEAR is ignored: no restart, colour unchanged.
- Ordering: a CPU write pushed during or in the same cycle as clr_start lands after the whole clear, so software may clear and then draw immediately.
- Latency:
  - CPU write, IDLE with empty FIFO: first clock sampling cpu_we=1 is E0; push at E1; pop at E2; ram_we=1 in the cycle after E2.
  - Clear: clr_start sampled at edge C0; writes occupy the NUM_WORDS cycles following C0+1, addresses 0..NUM_WORDS-1 ascending.
- busy = (state==CLEAR) | FIFO non-empty | (ram_we pending from a pop).
- Widths: counter is ADDR_W+1 bits so NUM_WORDS=128 terminates correctly. Address never wraps during a clear.

Test Plan:
- Single CPU write: reset, cpu_addr=7'h05, cpu_din=24'hFF0000, raise cpu_we and hold 10 cycles -> exactly one ram_we pulse with addr 5 / data FF0000, 3 cycles after the first sampled high; busy returns to 0.
- Clear: clr_color=24'h00FF00, clr_start pulse -> 128 consecutive ram_we cycles, addr 0..127, data 00FF00; busy low 1 cycle after address 127.
- Clear then draw: clr_start, then 2 CPU writes (addr 10, addr 20) during the clear -> both written after address 127, in push order, with no gap greater than 1 cycle.
- Overflow: during a clear, issue 6 CPU strobes (addr 0..5) -> entries 0..3 written after the clear, entries 4..5 dropped, ovf=1; ovf_clr pulse -> ovf=0.
- Ignored restart: clr_start with colour A, second clr_start with colour B at write 50 -> 128 writes total, all colour A.
- Reset mid-clear: assert rst_n=0 at write 30 -> all outputs 0 immediately (async); after release, no ram_we until a new request.
